// File: rtl/ex_pkg.sv
// Shared encodings for the Morty multi-cycle execute stage.
package ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SLL   = 4'd1,
        OP_SUB   = 4'd2,
        OP_SRA   = 4'd3,
        OP_XOR   = 4'd4,
        OP_SRL   = 4'd5,
        OP_OR    = 4'd6,
        OP_AND   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13,
        OP_DIV   = 4'd14,
        OP_REM   = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } ex_state_e;

    // Every op from MUL upwards runs on the iterative unit.
    function automatic logic is_multicycle(input alu_op_e op);
        return op >= OP_MUL;
    endfunction

endpackage

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M unit: shift-add multiply and restoring divide, one bit per cycle.
module ex_muldiv_seq
    import ex_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_c_o,
    output logic [XLEN-1:0] result_c_o
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    alu_op_e          op_q;
    logic [XLEN-1:0]  opnd_q, hi_q, lo_q, a_raw_q;
    logic             qneg_q, rneg_q, div0_q;

    logic             is_mul, is_signed;
    logic [XLEN-1:0]  a_mag, b_mag, hi_n, lo_n;
    logic [XLEN:0]    sum, shifted, diff;

    always_comb begin
        is_mul    = (alu_op_e'(op_i) == OP_MUL) || (alu_op_e'(op_i) == OP_MULHU);
        is_signed = (alu_op_e'(op_i) == OP_DIV) || (alu_op_e'(op_i) == OP_REM);
        a_mag     = (is_signed && a_i[XLEN-1]) ? -a_i : a_i;
        b_mag     = (is_signed && b_i[XLEN-1]) ? -b_i : b_i;
    end

    // Next value of the {hi, lo} pair after one iteration.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, opnd_q};
        hi_n    = hi_q;
        lo_n    = lo_q;
        if (op_q == OP_MUL || op_q == OP_MULHU) begin
            {hi_n, lo_n} = {sum, lo_q[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            hi_n = diff[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            hi_n = shifted[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], 1'b0};
        end
    end

    // Final result taken from the last iteration, with sign and divide-by-zero fix-up.
    always_comb begin
        result_c_o = '0;
        case (op_q)
            OP_MUL:          result_c_o = lo_n;
            OP_MULHU:        result_c_o = hi_n;
            OP_DIVU, OP_DIV: result_c_o = div0_q ? '1 : (qneg_q ? -lo_n : lo_n);
            OP_REMU, OP_REM: result_c_o = div0_q ? a_raw_q : (rneg_q ? -hi_n : hi_n);
            default:         result_c_o = '0;
        endcase
    end

    assign done_c_o = busy_q && (cnt_q == CNT_W'(1));
    assign busy_o   = busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            op_q    <= OP_ADD;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_raw_q <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else if (kill_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            cnt_q   <= CNT_W'(XLEN);
            op_q    <= alu_op_e'(op_i);
            opnd_q  <= is_mul ? a_i : b_mag;
            hi_q    <= '0;
            lo_q    <= is_mul ? b_i : a_mag;
            a_raw_q <= a_i;
            qneg_q  <= is_signed && (a_i[XLEN-1] ^ b_i[XLEN-1]);
            rneg_q  <= is_signed && a_i[XLEN-1];
            div0_q  <= !is_mul && (b_i == '0);
        end else if (busy_q) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage_mc.sv
// Morty execute stage: 1-cycle ALU, iterative mul/div, valid/ready on both sides, flush via kill_i.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned TRAP_W = 11,
    parameter int unsigned CSRA_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              kill_i,
    input  logic [3:0]        alu_op_i,
    input  logic [XLEN-1:0]   src_A_i,
    input  logic [XLEN-1:0]   src_B_i,
    input  logic [XLEN-1:0]   PC_i,
    input  logic [XLEN-1:0]   PC4_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic [XLEN-1:0]   csr_data_i,
    input  logic [CSRA_W-1:0] csr_addr_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [TRAP_W-1:0] trap_code_i,
    input  logic              is_trap_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   alu_out_o,
    output logic [XLEN-1:0]   PC_o,
    output logic [XLEN-1:0]   PC4_o,
    output logic [RD_W-1:0]   rd_o,
    output logic [XLEN-1:0]   csr_data_o,
    output logic [CSRA_W-1:0] csr_addr_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic [TRAP_W-1:0] trap_code_o,
    output logic              is_trap_o
);

    localparam int unsigned SH_W = $clog2(XLEN);

    ex_state_e         state_q;
    logic              valid_q, is_trap_q;
    logic [XLEN-1:0]   alu_out_q, pc_q, pc4_q, csr_data_q, rs2_data_q;
    logic [RD_W-1:0]   rd_q;
    logic [CSRA_W-1:0] csr_addr_q;
    logic [TRAP_W-1:0] trap_code_q;

    logic              accept, op_mc, md_start, md_busy, md_done;
    logic [XLEN-1:0]   alu_c, md_result;
    logic [SH_W-1:0]   shamt;

    assign ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_i);
    assign accept   = valid_i && ready_o && !kill_i;
    assign op_mc    = is_multicycle(alu_op_e'(alu_op_i)) && !is_trap_i;
    assign md_start = accept && op_mc;

    // Single-cycle ALU.
    always_comb begin
        alu_c = '0;
        shamt = src_B_i[SH_W-1:0];
        case (alu_op_e'(alu_op_i))
            OP_ADD:  alu_c = src_A_i + src_B_i;
            OP_SLL:  alu_c = src_A_i << shamt;
            OP_SUB:  alu_c = src_A_i - src_B_i;
            OP_SRA:  alu_c = XLEN'($signed(src_A_i) >>> shamt);
            OP_XOR:  alu_c = src_A_i ^ src_B_i;
            OP_SRL:  alu_c = src_A_i >> shamt;
            OP_OR:   alu_c = src_A_i | src_B_i;
            OP_AND:  alu_c = src_A_i & src_B_i;
            OP_SLT:  alu_c = XLEN'($signed(src_A_i) < $signed(src_B_i));
            OP_SLTU: alu_c = XLEN'(src_A_i < src_B_i);
            default: alu_c = '0;
        endcase
    end

    ex_muldiv_seq #(.XLEN(XLEN)) u_muldiv (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (md_start),
        .kill_i     (kill_i),
        .op_i       (alu_op_i),
        .a_i        (src_A_i),
        .b_i        (src_B_i),
        .busy_o     (md_busy),
        .done_c_o   (md_done),
        .result_c_o (md_result)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            valid_q     <= 1'b0;
            alu_out_q   <= '0;
            pc_q        <= '0;
            pc4_q       <= '0;
            rd_q        <= '0;
            csr_data_q  <= '0;
            csr_addr_q  <= '0;
            rs2_data_q  <= '0;
            trap_code_q <= '0;
            is_trap_q   <= 1'b0;
        end else if (kill_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        pc_q        <= PC_i;
                        pc4_q       <= PC4_i;
                        rd_q        <= rd_i;
                        csr_data_q  <= csr_data_i;
                        csr_addr_q  <= csr_addr_i;
                        rs2_data_q  <= rs2_data_i;
                        trap_code_q <= trap_code_i;
                        is_trap_q   <= is_trap_i;
                        if (op_mc) begin
                            state_q <= S_BUSY;
                            valid_q <= 1'b0;
                        end else begin
                            state_q   <= S_DONE;
                            valid_q   <= 1'b1;
                            alu_out_q <= is_trap_i ? '0 : alu_c;
                        end
                    end else if ((state_q == S_DONE) && ready_i) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (md_done) begin
                        state_q   <= S_DONE;
                        valid_q   <= 1'b1;
                        alu_out_q <= md_result;
                    end else if (!md_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign valid_o     = valid_q;
    assign alu_out_o   = alu_out_q;
    assign PC_o        = pc_q;
    assign PC4_o       = pc4_q;
    assign rd_o        = rd_q;
    assign csr_data_o  = csr_data_q;
    assign csr_addr_o  = csr_addr_q;
    assign rs2_data_o  = rs2_data_q;
    assign trap_code_o = trap_code_q;
    assign is_trap_o   = is_trap_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc: directed vectors, expected beats queued at accept.
module tb_ex_stage_mc;
    import ex_pkg::*;

    logic        clk, rst_i, valid_i, ready_o, kill_i, ready_i, valid_o, is_trap_i, is_trap_o;
    logic [3:0]  alu_op_i;
    logic [31:0] src_A_i, src_B_i, PC_i, PC4_i, csr_data_i, rs2_data_i;
    logic [31:0] alu_out_o, PC_o, PC4_o, csr_data_o, rs2_data_o;
    logic [4:0]  rd_i, rd_o;
    logic [11:0] csr_addr_i, csr_addr_o;
    logic [10:0] trap_code_i, trap_code_o;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [11:0] csra;
        logic [31:0] csrd;
        logic [31:0] rs2;
        logic [10:0] tc;
        logic        trap;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    ex_stage_mc dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .kill_i(kill_i),
        .alu_op_i(alu_op_i), .src_A_i(src_A_i), .src_B_i(src_B_i), .PC_i(PC_i), .PC4_i(PC4_i),
        .rd_i(rd_i), .csr_data_i(csr_data_i), .csr_addr_i(csr_addr_i), .rs2_data_i(rs2_data_i),
        .trap_code_i(trap_code_i), .is_trap_i(is_trap_i), .valid_o(valid_o), .ready_i(ready_i),
        .alu_out_o(alu_out_o), .PC_o(PC_o), .PC4_o(PC4_o), .rd_o(rd_o), .csr_data_o(csr_data_o),
        .csr_addr_o(csr_addr_o), .rs2_data_o(rs2_data_o), .trap_code_o(trap_code_o),
        .is_trap_o(is_trap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every beat handed downstream is compared against the head of the queue.
    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i && !kill_i) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got alu %h expected no beat", alu_out_o);
            end else begin
                mon_e = q.pop_front();
                check("alu_out", 64'(alu_out_o), 64'(mon_e.alu));
                check("pc_pc4", {PC_o, PC4_o}, {mon_e.pc, mon_e.pc4});
                check("side", 64'({rd_o, csr_addr_o, trap_code_o, is_trap_o}),
                      64'({mon_e.rd, mon_e.csra, mon_e.tc, mon_e.trap}));
                check("data", {csr_data_o, rs2_data_o}, {mon_e.csrd, mon_e.rs2});
            end
        end
    end

    // Drive one beat from just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_alu, input logic [31:0] pc, input logic trap,
                         input logic [10:0] tc, input bit push, output int waits);
        exp_t e;
        alu_op_i = op; src_A_i = a; src_B_i = b;
        PC_i = pc; PC4_i = pc + 32'd4; rd_i = pc[6:2];
        csr_addr_i = pc[11:0] ^ 12'h300; csr_data_i = pc ^ 32'hA5A5_0000; rs2_data_i = ~pc;
        trap_code_i = tc; is_trap_i = trap;
        valid_i = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!ready_o && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!ready_o) begin
            check("accept_timeout", 64'(ready_o), 64'(1));
        end else if (push) begin
            e = '{alu: exp_alu, pc: pc, pc4: pc + 32'd4, rd: pc[6:2], csra: pc[11:0] ^ 12'h300,
                  csrd: pc ^ 32'hA5A5_0000, rs2: ~pc, tc: tc, trap: trap};
            q.push_back(e);
        end
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_o && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_alu, input logic [31:0] pc, input int exp_lat,
                       input logic trap, input logic [10:0] tc);
        int w, n;
        issue(op, a, b, exp_alu, pc, trap, tc, 1'b1, w);
        wait_valid(n);
        check("latency", 64'(n + 1), 64'(exp_lat));
    endtask

    initial begin
        int w, n, vcnt;
        rst_i = 1'b1; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
        alu_op_i = '0; src_A_i = '0; src_B_i = '0; PC_i = '0; PC4_i = '0; rd_i = '0;
        csr_data_i = '0; csr_addr_i = '0; rs2_data_i = '0; trap_code_i = '0; is_trap_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid_o), 64'(0));
        check("rst_ready", 64'(ready_o), 64'(1));
        check("rst_outs", {alu_out_o, PC_o}, 64'(0));
        check("rst_side", 64'({rd_o, csr_addr_o, trap_code_o, is_trap_o}), 64'(0));
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Single-cycle ALU ops.
        run(OP_ADD,  32'd5,          32'd7,  32'd12,         32'h0000_0100, 1, 1'b0, 11'h0);
        run(OP_SLL,  32'd1,          32'd33, 32'd2,          32'h0000_0104, 1, 1'b0, 11'h0);
        run(OP_SRA,  32'h8000_0000,  32'd4,  32'hF800_0000,  32'h0000_0108, 1, 1'b0, 11'h0);
        run(OP_SRL,  32'h8000_0000,  32'd4,  32'h0800_0000,  32'h0000_010C, 1, 1'b0, 11'h0);
        run(OP_SUB,  32'd5,          32'd7,  32'hFFFF_FFFE,  32'h0000_0110, 1, 1'b0, 11'h0);
        run(OP_SLT,  32'hFFFF_FFFF,  32'd1,  32'd1,          32'h0000_0114, 1, 1'b0, 11'h0);
        run(OP_SLTU, 32'hFFFF_FFFF,  32'd1,  32'd0,          32'h0000_0118, 1, 1'b0, 11'h0);
        run(OP_XOR,  32'hF0F0_1234,  32'hFF00_FF00, 32'h0FF0_ED34, 32'h0000_011C, 1, 1'b0, 11'h0);

        // Multiply / divide, including divide-by-zero and signed overflow.
        run(OP_MUL,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 32'h0000_0200, 33, 1'b0, 11'h0);
        run(OP_MULHU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'h0000_0204, 33, 1'b0, 11'h0);
        run(OP_DIVU,  32'd7,         32'd0,         32'hFFFF_FFFF, 32'h0000_0208, 33, 1'b0, 11'h0);
        run(OP_REMU,  32'd7,         32'd0,         32'd7,         32'h0000_020C, 33, 1'b0, 11'h0);
        run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0210, 33, 1'b0, 11'h0);
        run(OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h0000_0214, 33, 1'b0, 11'h0);
        run(OP_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'h0000_0218, 33, 1'b0, 11'h0);
        run(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'h0000_021C, 33, 1'b0, 11'h0);
        run(OP_DIVU,  32'd100,       32'd7,         32'd14,        32'h0000_0220, 33, 1'b0, 11'h0);
        run(OP_REMU,  32'd100,       32'd7,         32'd2,         32'h0000_0224, 33, 1'b0, 11'h0);
        run(OP_DIV,   32'd7,         32'd0,         32'hFFFF_FFFF, 32'h0000_0228, 33, 1'b0, 11'h0);

        // Trapped beats pass through in one cycle with a zero result.
        run(OP_ADD, 32'd5,  32'd7, 32'd0, 32'h0000_0300, 1, 1'b1, 11'h004);
        run(OP_DIV, 32'd10, 32'd2, 32'd0, 32'h0000_0304, 1, 1'b1, 11'h400);

        // Backpressure: held beat stays stable, then a back-to-back accept.
        @(posedge clk);
        #1 ready_i = 1'b0;
        issue(OP_ADD, 32'd1, 32'd1, 32'd2, 32'h0000_0400, 1'b0, 11'h0, 1'b1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {30'(0), valid_o, ready_o, alu_out_o}, {30'(0), 1'b1, 1'b0, 32'd2});
        end
        @(posedge clk);
        #1 ready_i = 1'b1;
        issue(OP_ADD, 32'd3, 32'd4, 32'd7, 32'h0000_0404, 1'b0, 11'h0, 1'b1, w);
        check("b2b_wait", 64'(w), 64'(0));
        check("b2b_valid", 64'(valid_o), 64'(1));

        // Kill on the tenth busy cycle drops the divide.
        @(posedge clk);
        #1;
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 32'h0000_0500, 1'b0, 11'h0, 1'b0, w);
        repeat (9) @(posedge clk);
        #1 kill_i = 1'b1;
        @(posedge clk);
        #1 kill_i = 1'b0;
        check("kill_valid", 64'(valid_o), 64'(0));
        check("kill_ready", 64'(ready_o), 64'(1));
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (valid_o) vcnt++;
        end
        check("kill_no_beat", 64'(vcnt), 64'(0));
        run(OP_ADD, 32'd20, 32'd22, 32'd42, 32'h0000_0508, 1, 1'b0, 11'h0);

        // Asynchronous reset mid-multiply clears everything before the next edge.
        @(posedge clk);
        #1;
        issue(OP_MUL, 32'd3, 32'd3, 32'd9, 32'h0000_0600, 1'b0, 11'h0, 1'b0, w);
        repeat (5) @(posedge clk);
        #3 rst_i = 1'b1;
        #1;
        check("arst_outs", {alu_out_o, PC_o}, 64'(0));
        check("arst_ctrl", 64'({valid_o, ready_o, rd_o}), 64'({1'b0, 1'b1, 5'd0}));
        @(posedge clk);
        #1 rst_i = 1'b0;
        wait_valid(n);
        check("arst_no_beat", 64'(n), 64'(200));
        run(OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 32'h0000_0604, 1, 1'b0, 11'h0);

        repeat (3) @(posedge clk);
        #1 check("queue_empty", 64'(q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
